vrf_port_arbiter: RTL
=====================

# vrf_port_arbiter

Shares the single access port of the 8×256-bit vector register file between `NREQ` requesters (execution lanes, load unit) using round-robin arbitration. It sequences reads so that returned data is captured in the grant cycle and tagged back to the winning requester. It enforces ordering against the traffic-feature ingest path, which writes register 0 directly. The block sits between the FPE issue logic and the vector register file and is the only driver of the file's `wr_rf`, `rd_rf`, `rf_sel` and `wrf_data` inputs.

## Interface
Parameters:
- `NREQ`, 3: number of requesters (2..8).
- `DW`, 256: vector data width.
- `AW`, 3: register select width (8 registers).
- `CW`, 16: stall counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NREQ: request pending per requester.
- `req_we`, in, NREQ: 1 = write, 0 = read, per requester.
- `req_sel`, in, NREQ*AW: register select per requester; slice i belongs to requester i.
- `req_wdata`, in, NREQ*DW: write data per requester.
- `req_ready`, out, NREQ: one-hot grant, combinational, same cycle.
- `rsp_valid`, out, NREQ: one-hot read-response strobe, registered.
- `rsp_data`, out, DW: read data for the requester flagged in `rsp_valid`.
- `ingest_v`, in, 1: feature-ingest write to register 0 this cycle; mirrors the file's `wrf0_data_v`.
- `rf_wr`, out, 1: to file `wr_rf`.
- `rf_rd`, out, 1: to file `rd_rf`.
- `rf_sel`, out, AW: to file `rf_sel`.
- `rf_wdata`, out, DW: to file `wrf_data`.
- `rf_rdata`, in, DW: from file `rrf_data`, combinational on `rf_sel`.
- `stall_cnt`, out, CW: saturating count of cycles in which an ingest conflict blocked a request.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and it is not blocked by ingest.
  - A request is blocked when `ingest_v`=1 and its `req_sel`=0, whether it is a read or a write.
  - Blocked writes would otherwise be dropped by the file.
  - Blocked reads would otherwise return pre-ingest data.
- **Round-robin arbitration:** pointer `rr_ptr` marks the highest-priority requester.
  - Grant the first eligible requester scanning `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
  - After a grant to requester g, `rr_ptr` ← (g+1) mod NREQ.
  - With no grant, `rr_ptr` holds.
- **Port drive, combinational from the winner:**
  - `rf_sel` = winner's `req_sel`.
  - `rf_wdata` = winner's `req_wdata`.
  - `rf_wr` = grant and we; `rf_rd` = grant and not we.
  - With no grant, `rf_wr`=`rf_rd`=0, and `rf_sel`/`rf_wdata` are 0.
- **Read capture:** on a read grant, `rf_rdata` is registered into `rsp_data` at the end of the grant cycle, and `rsp_valid[g]` pulses for exactly one cycle.
  - `rsp_data` holds its value until the next read grant.
- **Stall counter:** `stall_cnt` increments in any cycle where at least one requester has `req_valid` high and is blocked.
  - It saturates at all-ones.
- **Handshake:** a requester holds `req_valid`, `req_we`, `req_sel` and `req_wdata` stable until it sees `req_ready`.
  - Dropping `req_valid` before the grant is legal and simply withdraws the request.

## Timing
- **Reset values:** `rr_ptr`=0, `rsp_valid`=0, `rsp_data`=0, `stall_cnt`=0. Combinational outputs are 0 while no requests are pending.
- **Write latency:** a write is committed to the file at the clock edge ending its grant cycle T.
- **Read latency:** a read granted in cycle T gives `rsp_valid`/`rsp_data` in T+1.
  - Back-to-back reads give one response per cycle.
- **Read-after-write:** a write granted in T followed by a read of the same register granted in T+1 returns the new data.
- **Ingest arbitration:** ingest always wins register 0. A request blocked in T is re-arbitrated in T+1 and sees the ingested value.
- **Reset mid-operation:** reset asserted in cycle T suppresses any `rsp_valid` in T+1. Requests issued but not yet granted are not remembered.
- **Single requester:** a single continuously requesting master is granted every cycle. The pointer still advances.

## Structure
- **Package `vrf_pkg`:** `VRF_DW`=256, `VRF_AW`=3, `VRF_NREGS`=8, `VRF_INGEST_REG`=0, and a typedef `vrf_req_t` {we, sel, wdata}.
- **Sub-module `rr_arbiter`:** parameter N; inputs `clk`, `rst`, eligible mask; outputs one-hot grant and grant index; owns `rr_ptr`.
- **Top level:** eligibility masking, port mux, response register and stall counter stay in the top level.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req_valid`=1 → no `req_ready`, no `rf_wr`/`rf_rd` during reset; `rsp_valid`=0, `stall_cnt`=0 after release.
- **Round-robin fairness:** all 3 requesters reading regs 1/2/3 continuously → grant order 0,1,2,0,1,2; `rsp_valid` one-hot in T+1 with the matching register contents.
- **Write then read:** req0 writes 0xA5…A5 to reg 5 in T; req1 reads reg 5 in T+1 → `rsp_valid`=3'b010 in T+2 with `rsp_data`=0xA5…A5.
- **Ingest conflict:** `ingest_v`=1 with data 0x11…11 while req2 writes reg 0 → no grant to req2 that cycle, `stall_cnt`=1; req2 granted the next cycle, and reg 0 finally holds req2's data.
- **Ingest, read of reg 0:** `ingest_v`=1 while req1 reads reg 0 and req0 reads reg 4 → req0 granted; req1 granted next cycle and returns the ingested 0x11…11.
- **Saturation and withdrawal:** force `CW`=4 with a blocked request for 20 cycles → `stall_cnt` stops at 15; drop `req_valid` before its grant → no grant and no file access occurs.

Source files
------------

// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared constants and request type for the vector register file port
package vrf_pkg;

  localparam int VRF_DW         = 256;
  localparam int VRF_AW         = 3;
  localparam int VRF_NREGS      = 8;
  localparam int VRF_INGEST_REG = 0;

  typedef struct packed {
    logic              we;
    logic [VRF_AW-1:0] sel;
    logic [VRF_DW-1:0] wdata;
  } vrf_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the priority pointer
module rr_arbiter
  import vrf_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  elig_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;
  logic           any;

  // Rotate the mask so the pointer lands at bit 0; the first set bit is the winner's offset.
  always_comb begin
    dbl       = {elig_i, elig_i} >> rr_ptr_q;
    rot       = dbl[N-1:0];
    sum       = '0;
    any       = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
        any = 1'b1;
      end
    end
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    if (any) begin
      gnt_idx_o = sum[IW-1:0];
      gnt_o     = {{(N-1){1'b0}}, 1'b1} << sum[IW-1:0];
      rr_ptr_d  = (sum[IW-1:0] == IW'(N - 1)) ? '0 : sum[IW-1:0] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/vrf_port_arbiter.sv
// rtl/vrf_port_arbiter.sv - shares the vector register file port between requesters
module vrf_port_arbiter
  import vrf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = VRF_DW,
  parameter int AW   = VRF_AW,
  parameter int CW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_sel,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  input  logic             ingest_v,
  output logic             rf_wr,
  output logic             rf_rd,
  output logic [AW-1:0]    rf_sel,
  output logic [DW-1:0]    rf_wdata,
  input  logic [DW-1:0]    rf_rdata,
  output logic [CW-1:0]    stall_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0]   sel_a   [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];
  logic [NREQ-1:0] blocked, elig, gnt, rd_gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [CW-1:0]   stall_q, stall_d;

  // Ingest owns register 0 for the cycle, so any access to it must wait a cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      sel_a[i]   = req_sel[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
      blocked[i] = ingest_v && (sel_a[i] == AW'(VRF_INGEST_REG));
    end
  end

  assign elig = req_valid & ~blocked & {NREQ{~rst}};

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .elig_i    (elig),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_any   = |gnt;
  assign rd_gnt    = gnt & ~req_we;
  assign req_ready = gnt;
  assign rf_wr     = |(gnt & req_we);
  assign rf_rd     = |rd_gnt;
  assign rf_sel    = gnt_any ? sel_a[gnt_idx]   : '0;
  assign rf_wdata  = gnt_any ? wdata_a[gnt_idx] : '0;

  always_comb begin
    rsp_valid_d = rd_gnt;
    rsp_data_d  = rf_rd ? rf_rdata : rsp_data_q;
    stall_d     = stall_q;
    if (|(req_valid & blocked) && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      stall_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      stall_q     <= stall_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign stall_cnt = stall_q;

endmodule
